uart_tx_ctrl: RTL and testbench

Transmit-side controller for the UART peripheral. It buffers bytes written by the peripheral register interface in a FIFO and feeds them one at a time into the UART transmitter through its valid/busy interface. It holds the transmitter's line configuration (baud rate, parity enable, stop bits) stable for the whole frame and signals when the queue has fully drained. It sits between the peripheral bus-side register logic and the uart_tx instance.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_tx_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART peripheral: controller state encoding
// and the supported baud rates.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } uart_tx_ctrl_state_t;

    localparam logic [16:0] UART_BAUD_9600   = 17'd9600;
    localparam logic [16:0] UART_BAUD_19200  = 17'd19200;
    localparam logic [16:0] UART_BAUD_38400  = 17'd38400;
    localparam logic [16:0] UART_BAUD_57600  = 17'd57600;
    localparam logic [16:0] UART_BAUD_115200 = 17'd115200;

    localparam logic [16:0] UART_DEFAULT_BAUD = UART_BAUD_9600;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head read and a flush that clears it in one cycle.
// Shared by the transmit and receive sides of the UART.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // A push during flush is discarded, so the queue is truly empty afterwards.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Transmit-side controller: queues bytes from the register interface and launches them
// one at a time into the UART transmitter, freezing the line configuration per frame.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_valid_i,
    input  logic [7:0]             wr_data_i,
    output logic                   wr_ready_o,
    input  logic                   flush_i,
    input  logic [16:0]            baudrate_i,
    input  logic                   parity_en_i,
    input  logic                   stopbit_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_busy_i,
    output logic [16:0]            baudrate_o,
    output logic                   parity_en_o,
    output logic                   stopbit_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] TMO_ONE  = CW'(1);

    uart_tx_ctrl_state_t state;
    uart_tx_ctrl_state_t state_nxt;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic          push_ok;
    logic          pop;
    logic          load;
    logic          tmo_clr;
    logic          tmo_inc;
    logic          set_err;
    logic          done_nxt;
    logic [CW-1:0] tmo_cnt;

    assign push_ok    = wr_valid_i && !fifo_full && !flush_i;
    assign wr_ready_o = !fifo_full;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush_i),
        .push  (wr_valid_i),
        .wdata (wr_data_i),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_o)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        set_err   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !tx_busy_i) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_clr   = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                // Queue counts as drained if it is empty or being flushed, unless a byte lands now.
                if (!tx_busy_i) begin
                    state_nxt = IDLE;
                    done_nxt  = (fifo_empty || flush_i) && !push_ok;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            tx_data_o   <= '0;
            baudrate_o  <= UART_DEFAULT_BAUD;
            parity_en_o <= 1'b0;
            stopbit_o   <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_o <= done_nxt;
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TMO_ONE;
            if (set_err) err_o <= 1'b1;
            // Configuration is only sampled at the pop, so it stays frozen for the whole frame.
            if (load) begin
                tx_data_o   <= fifo_rdata;
                baudrate_o  <= baudrate_i;
                parity_en_o <= parity_en_i;
                stopbit_o   <= stopbit_i;
            end
        end
    end

    assign tx_valid_o = (state == LAUNCH);
    assign busy_o     = (count_o != '0) || (state != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed-sequence bench for uart_tx_ctrl with a behavioural transmitter and a
// launch/done scoreboard; random bytes and random frame timing.
module tb_uart_tx_ctrl;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 4;
    localparam int CNTW         = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic [7:0]      wr_data;
    logic            wr_ready;
    logic            flush;
    logic [16:0]     baudrate;
    logic            parity_en;
    logic            stopbit;
    logic [CNTW-1:0] count;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_busy;
    logic [16:0]     baudrate_o;
    logic            parity_en_o;
    logic            stopbit_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    uart_tx_ctrl #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_valid_i  (wr_valid),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .flush_i     (flush),
        .baudrate_i  (baudrate),
        .parity_en_i (parity_en),
        .stopbit_i   (stopbit),
        .count_o     (count),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_busy_i   (tx_busy),
        .baudrate_o  (baudrate_o),
        .parity_en_o (parity_en_o),
        .stopbit_o   (stopbit_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Scoreboard of everything the DUT launched, never cleared; tests work on deltas.
    logic [7:0]  launch_q [$];
    int          lcyc_q   [$];
    logic [16:0] baud_q   [$];
    logic        par_q    [$];
    logic        stop_q   [$];
    int          fall_q   [$];
    int          done_n   = 0;
    int          done_cyc = 0;
    int          err_cyc  = -1;
    logic        err_prev = 1'b0;

    logic mute     = 1'b0;
    logic hold     = 1'b0;
    int   flen_min = 3;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (tx_valid === 1'b1) begin
            launch_q.push_back(tx_data);
            lcyc_q.push_back(cyc);
            baud_q.push_back(baudrate_o);
            par_q.push_back(parity_en_o);
            stop_q.push_back(stopbit_o);
        end
        if (done_o === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
        if (err_o === 1'b1 && !err_prev) err_cyc = cyc;
        err_prev = (err_o === 1'b1);
    end

    // Transmitter model: busy rises 1..3 cycles after a launch and lasts flen_min..flen_min+5 cycles.
    initial begin
        int lag_cnt;
        int len_cnt;
        int seen_n;
        logic held;
        lag_cnt = 0;
        len_cnt = 0;
        seen_n  = 0;
        held    = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (launch_q.size() > seen_n) begin
                seen_n = launch_q.size();
                if (!mute) lag_cnt = $urandom_range(1, 3);
            end
            if (hold) begin
                tx_busy = 1'b1;
                held    = 1'b1;
            end else if (held) begin
                tx_busy = 1'b0;
                held    = 1'b0;
            end else if (tx_busy) begin
                len_cnt--;
                if (len_cnt == 0) begin
                    tx_busy = 1'b0;
                    fall_q.push_back(cyc);
                end
            end else if (lag_cnt > 0) begin
                lag_cnt--;
                if (lag_cnt == 0) begin
                    tx_busy = 1'b1;
                    len_cnt = flen_min + $urandom_range(0, 5);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_o !== 1'b0 || tx_busy) && n < 3000);
        check({tag, "_idle"}, {31'd0, busy_o | tx_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!tx_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_busyup"}, {31'd0, tx_busy}, 32'd1);
    endtask

    task automatic wait_launch(input string tag, input int tgt);
        int n = 0;
        while (launch_q.size() < tgt && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_launch"}, launch_q.size(), tgt);
    endtask

    initial begin
        int lb;
        int db;
        int fb;
        int w;
        int occ;
        int n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp_q [$];

        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0;
        baudrate = 17'd9600; parity_en = 1'b0; stopbit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_baud", baudrate_o, 9600);
        check("rst_par", parity_en_o, 0);
        check("rst_stop", stopbit_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte: launch two cycles after the write, one done.
        lb = launch_q.size(); db = done_n;
        b0 = 8'($urandom);
        w = cyc; wr_valid = 1'b1; wr_data = b0;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_idle("t1");
        check("t1_nlaunch", launch_q.size() - lb, 1);
        check("t1_data", launch_q[lb], b0);
        check("t1_latency", lcyc_q[lb], w + 2);
        check("t1_done", done_n - db, 1);
        check("t1_count", count, 0);

        // Three back-to-back bytes: in order, each relaunch two cycles after busy falls.
        lb = launch_q.size(); db = done_n; fb = fall_q.size();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i + 1);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wait_idle("t2");
        check("t2_nlaunch", launch_q.size() - lb, 3);
        for (int i = 0; i < 3; i++) check("t2_data", launch_q[lb+i], i + 1);
        for (int i = 1; i < 3; i++) check("t2_gap", lcyc_q[lb+i], fall_q[fb+i-1] + 2);
        check("t2_done", done_n - db, 1);
        check("t2_done_last", {31'd0, done_cyc > lcyc_q[lb+2]}, 1);

        // Overfill with the transmitter held busy: extra bytes dropped, DEPTH frames sent.
        lb = launch_q.size(); db = done_n;
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        occ = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            check("t3_count", count, occ);
            check("t3_ready", {31'd0, wr_ready}, {31'd0, occ < DEPTH});
            wr_valid = 1'b1; wr_data = 8'($urandom);
            if (occ < DEPTH) begin
                exp_q.push_back(wr_data);
                occ++;
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        check("t3_full_count", count, DEPTH);
        check("t3_full_ready", wr_ready, 0);
        hold = 1'b0;
        wait_idle("t3");
        check("t3_nlaunch", launch_q.size() - lb, DEPTH);
        for (int i = 0; i < DEPTH; i++) check("t3_data", launch_q[lb+i], exp_q[i]);
        check("t3_done", done_n - db, 1);

        // Configuration change mid-frame only takes effect at the next pop.
        flen_min = 6;
        lb = launch_q.size();
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 8'($urandom);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wait_busy("t4");
        baudrate = 17'd115200; parity_en = 1'b1; stopbit = 1'b1;
        n = 0;
        while (tx_busy && n < 100) begin
            check("t4_hold_baud", baudrate_o, 9600);
            @(posedge clk); #1;
            n++;
        end
        wait_idle("t4");
        check("t4_baud1", baud_q[lb], 9600);
        check("t4_par1", par_q[lb], 0);
        check("t4_baud2", baud_q[lb+1], 115200);
        check("t4_par2", par_q[lb+1], 1);
        check("t4_stop2", stop_q[lb+1], 1);

        // Transmitter never answers: timeout sets err, next byte still launched, no done.
        mute = 1'b1;
        lb = launch_q.size(); db = done_n;
        b0 = 8'($urandom); b1 = 8'($urandom);
        wr_valid = 1'b1; wr_data = b0;
        @(posedge clk); #1;
        wr_data = b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_idle("t5");
        check("t5_nlaunch", launch_q.size() - lb, 2);
        check("t5_data0", launch_q[lb], b0);
        check("t5_data1", launch_q[lb+1], b1);
        check("t5_err_time", err_cyc, lcyc_q[lb] + BUSY_TIMEOUT + 1);
        check("t5_next_launch", lcyc_q[lb+1], lcyc_q[lb] + BUSY_TIMEOUT + 2);
        check("t5_no_done", done_n - db, 0);
        check("t5_err_sticky", err_o, 1);
        mute = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_rst_err", err_o, 0);
        check("t5_rst_baud", baudrate_o, 9600);

        // Flush with a frame on the line: queue cleared, frame finishes, done pulses.
        flen_min = 15;
        lb = launch_q.size(); db = done_n;
        b0 = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_data = (i == 0) ? b0 : 8'($urandom);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wait_busy("t6");
        @(posedge clk); #1;
        check("t6_queued", count, 5);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'($urandom);
        @(posedge clk); #1;
        flush = 1'b0; wr_valid = 1'b0;
        check("t6_flushed", count, 0);
        check("t6_ready", wr_ready, 1);
        wait_idle("t6");
        check("t6_nlaunch", launch_q.size() - lb, 1);
        check("t6_data", launch_q[lb], b0);
        check("t6_done", done_n - db, 1);

        // Reset mid-frame returns everything to idle with no launch.
        flen_min = 3;
        lb = launch_q.size();
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 8'($urandom);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wait_launch("t7", lb + 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t7_valid", tx_valid, 0);
        check("t7_count", count, 0);
        check("t7_busy", busy_o, 0);
        @(posedge clk); #1;
        check("t7_valid2", tx_valid, 0);
        rst = 1'b0;
        wait_idle("t7");
        check("t7_nlaunch", launch_q.size() - lb, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
